// File: rtl/mips_rtype_pkg.sv
// Shared definitions for the R-type fetch/decode stage, the R-type control unit
// and their benches.
// Holds the fetch FSM state encoding, the R-type opcode, the instruction-register
// field bit positions, and the function-code constants.
package mips_rtype_pkg;

  // Fetch/decode FSM state encoding (2 bits, IDLE = 0).
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2,
    StHalt  = 2'd3
  } fd_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  // Instruction-register field positions.
  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  // R-type function codes understood by the control unit.
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SRL = 6'h02;

  // True when the word carries the R-type opcode.
  function automatic logic is_rtype(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_RTYPE;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register for the fetch/decode stage.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset, loads RESET_PC
//   load_en - advance the PC by PC_STEP on the next rising edge
//   pc      - current program counter
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Plain 32-bit add: the top address wraps to zero.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/rtype_fetch_decode.sv
// Instruction fetch and R-type field decode stage.
// Fetches words from instruction memory (req/ack), latches them into the IR and
// presents the decoded fields downstream (valid/ready). Halts on any non-R-type
// opcode until reset.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   start               - begin fetching from the current PC (IDLE only)
//   imem_req/addr       - instruction memory request and address (= pc)
//   imem_ack/rdata      - memory response strobe and data
//   dec_valid/ready     - decoded-field handshake
//   rs, rt, rd, shamt   - register and shift-amount fields from IR
//   function_code       - IR[5:0], consumed by the control unit
//   pc                  - address of the instruction held in IR
//   busy                - FETCH or ISSUE
//   illegal             - sticky, set when a non-R-type word is fetched
module rtype_fetch_decode
  import mips_rtype_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  function_code,
  output logic [31:0] pc,
  output logic        busy,
  output logic        illegal
);

  fd_state_e   state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        pc_advance;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    pc_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d = imem_rdata;
          if (is_rtype(imem_rdata)) begin
            state_d = StIssue;
          end else begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (dec_ready) begin
          pc_advance = 1'b1;
          state_d    = StFetch;
        end
      end
      StHalt: begin
        // Only reset leaves HALT.
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ir_q      <= 32'h0000_0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_advance),
    .pc      (pc)
  );

  // Moore outputs decoded from the state register only.
  assign imem_req  = (state_q == StFetch);
  assign dec_valid = (state_q == StIssue);
  assign busy      = (state_q == StFetch) || (state_q == StIssue);
  assign imem_addr = pc;
  assign illegal   = illegal_q;

  assign rs            = ir_q[RS_MSB:RS_LSB];
  assign rt            = ir_q[RT_MSB:RT_LSB];
  assign rd            = ir_q[RD_MSB:RD_LSB];
  assign shamt         = ir_q[SHAMT_MSB:SHAMT_LSB];
  assign function_code = ir_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_rtype_fetch_decode.sv
// Bench for rtype_fetch_decode: a default-PC instance plus a second instance
// reset to 32'hFFFF_FFFC (shares all inputs) to exercise PC wrap-around.
module tb_rtype_fetch_decode;
  import mips_rtype_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_ready;

  logic        imem_req, dec_valid, busy, illegal;
  logic [31:0] imem_addr, pc;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  function_code;

  logic        d1_imem_req, d1_dec_valid, d1_busy, d1_illegal;
  logic [31:0] d1_imem_addr, d1_pc;
  logic [4:0]  d1_rs, d1_rt, d1_rd, d1_shamt;
  logic [5:0]  d1_function_code;

  always #5 clk = ~clk;

  rtype_fetch_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .function_code (function_code),
    .pc            (pc),
    .busy          (busy),
    .illegal       (illegal)
  );

  rtype_fetch_decode #(
    .RESET_PC (32'hFFFF_FFFC),
    .PC_STEP  (4)
  ) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (d1_imem_req),
    .imem_addr     (d1_imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .dec_valid     (d1_dec_valid),
    .dec_ready     (dec_ready),
    .rs            (d1_rs),
    .rt            (d1_rt),
    .rd            (d1_rd),
    .shamt         (d1_shamt),
    .function_code (d1_function_code),
    .pc            (d1_pc),
    .busy          (d1_busy),
    .illegal       (d1_illegal)
  );

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
    int         ack_dly;
    int         rdy_dly;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        cur;
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected decode and compare it with the fields on display.
  task automatic pop_compare;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got output with no expected entry");
    end else begin
      cur = sb_q.pop_front();
      check("rs", 32'(rs), 32'(cur.rs));
      check("rt", 32'(rt), 32'(cur.rt));
      check("rd", 32'(rd), 32'(cur.rd));
      check("shamt", 32'(shamt), 32'(cur.shamt));
      check("function_code", 32'(function_code), 32'(cur.funct));
      check("pc", pc, cur.pc);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    for (int i = 0; i < v.ack_dly; i++) begin
      check("wait_imem_req", 32'(imem_req), 32'd1);
      check("wait_imem_addr", imem_addr, exp_pc);
      check("wait_no_dec_valid", 32'(dec_valid), 32'd0);
      tick();
    end
    check("ack_imem_req", 32'(imem_req), 32'd1);
    check("ack_imem_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = {OPC_RTYPE, v.rs, v.rt, v.rd, v.shamt, v.funct};
    e.rs = v.rs; e.rt = v.rt; e.rd = v.rd; e.shamt = v.shamt; e.funct = v.funct; e.pc = exp_pc;
    sb_q.push_back(e);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    n = 0;
    while (!dec_valid && n < 10) begin
      tick();
      n++;
    end
    check("dec_valid_latency", 32'(n), 32'd0);
    pop_compare();
    for (int i = 0; i < v.rdy_dly; i++) begin
      tick();
      check("hold_dec_valid", 32'(dec_valid), 32'd1);
      check("hold_no_imem_req", 32'(imem_req), 32'd0);
      check("hold_fields", {rs, rt, rd, shamt, function_code, 6'd0},
            {cur.rs, cur.rt, cur.rd, cur.shamt, cur.funct, 6'd0});
      check("hold_pc", pc, cur.pc);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    exp_pc = exp_pc + 32'd4;
    check("next_imem_addr", imem_addr, exp_pc);
    check("next_imem_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rs: 5'd5,  rt: 5'd6,  rd: 5'd4,  shamt: 5'd0, funct: FUNCT_SUB, ack_dly: 3, rdy_dly: 0};
    vecs[1] = '{rs: 5'd8,  rt: 5'd9,  rd: 5'd7,  shamt: 5'd0, funct: FUNCT_AND, ack_dly: 0, rdy_dly: 5};
    vecs[2] = '{rs: 5'd30, rt: 5'd29, rd: 5'd31, shamt: 5'd0, funct: FUNCT_OR,  ack_dly: 1, rdy_dly: 1};
    vecs[3] = '{rs: 5'd11, rt: 5'd12, rd: 5'd10, shamt: 5'd0, funct: FUNCT_SLT, ack_dly: 0, rdy_dly: 0};
    vecs[4] = '{rs: 5'd0,  rt: 5'd3,  rd: 5'd2,  shamt: 5'd7, funct: FUNCT_SRL, ack_dly: 2, rdy_dly: 2};
    vecs[5] = '{rs: 5'd31, rt: 5'd31, rd: 5'd31, shamt: 5'd31, funct: FUNCT_ADD, ack_dly: 0, rdy_dly: 0};

    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    dec_ready  = 1'b0;
    exp_pc     = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_fields", {27'd0, rs} | {27'd0, rt} | {27'd0, rd} | {27'd0, shamt} | {26'd0, function_code},
          32'd0);
    check("rst_wrap_pc", d1_pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    tick();

    // start idles the FSM into FETCH; zero-wait add $3,$1,$2.
    check("idle_imem_req", 32'(imem_req), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_imem_req", 32'(imem_req), 32'd1);
    check("start_imem_addr", imem_addr, 32'h0);
    check("start_busy", 32'(busy), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0022_1820;
    sb_q.push_back('{rs: 5'd1, rt: 5'd2, rd: 5'd3, shamt: 5'd0, funct: 6'h20, pc: 32'h0});
    tick();
    imem_ack = 1'b0;
    check("add_dec_valid", 32'(dec_valid), 32'd1);
    check("add_imem_req", 32'(imem_req), 32'd0);
    pop_compare();
    check("wrap_issue_pc", d1_pc, 32'hFFFF_FFFC);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    exp_pc = 32'h4;
    check("add_next_addr", imem_addr, 32'h4);
    check("add_next_req", 32'(imem_req), 32'd1);
    check("wrap_next_addr", d1_imem_addr, 32'h0);

    // Table-driven R-type stream with varied ack and ready delays.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Non-R-type word halts the stage.
    tick();
    check("pre_lw_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_0000;
    tick();
    imem_ack = 1'b0;
    check("lw_illegal", 32'(illegal), 32'd1);
    check("lw_busy", 32'(busy), 32'd0);
    check("lw_imem_req", 32'(imem_req), 32'd0);
    check("lw_dec_valid", 32'(dec_valid), 32'd0);
    check("lw_pc", pc, exp_pc);
    check("lw_ir_rs", 32'(rs), 32'd1);
    start      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0022_1820;
    repeat (2) tick();
    start    = 1'b0;
    imem_ack = 1'b0;
    tick();
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_illegal", 32'(illegal), 32'd1);
    check("halt_pc", pc, exp_pc);
    check("halt_rt", 32'(rt), 32'd2);
    check("halt_funct", 32'(function_code), 32'd0);
    check("halt_imem_req", 32'(imem_req), 32'd0);

    // Reset mid-request, then a late ack.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("rerst_illegal", 32'(illegal), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_imem_req", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_rd", 32'(rd), 32'd0);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0022_1820;
    tick();
    imem_ack = 1'b0;
    check("late_ack_busy", 32'(busy), 32'd0);
    check("late_ack_req", 32'(imem_req), 32'd0);
    check("late_ack_dec_valid", 32'(dec_valid), 32'd0);
    check("late_ack_rd", 32'(rd), 32'd0);
    check("late_ack_funct", 32'(function_code), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_fetch_decode.md
# rtype_fetch_decode

Instruction fetch and field-decode stage directly upstream of the R-type control unit and register file. Fetches 32-bit words from instruction memory over a request/acknowledge handshake, latches them into an instruction register and presents the decoded R-type fields, including the 6-bit `function_code` consumed by the control unit, under a valid/ready handshake. Owns the program counter. Halts on any non-R-type opcode.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `PC_STEP`, 4: byte increment per retired instruction.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin fetching from current PC; sampled only in IDLE.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_ack`  in  1  memory response valid.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `dec_valid`  out  1  decoded fields valid.
- `dec_ready`  in  1  downstream accepts fields.
- `rs`, `rt`, `rd`  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- `shamt`  out  5  IR[10:6].
- `function_code`  out  6  IR[5:0]; feeds control unit.
- `pc`  out  32  address of the instruction held in IR.
- `busy`  out  1  state is FETCH or ISSUE.
- `illegal`  out  1  sticky; set on non-zero opcode.

## Operation
- States: IDLE, FETCH, ISSUE, HALT. Encoding 2 bits, IDLE=0.
- IDLE: all handshake outputs 0. `start`=1 -> FETCH. `start` ignored in every other state.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`=1: IR <= `imem_rdata`; if `imem_rdata[31:26]`==6'h00 -> ISSUE, else -> HALT with `illegal`<=1. Without ack, hold request and address unchanged indefinitely.
- ISSUE: `dec_valid`=1, all field outputs driven from IR and stable. On `dec_ready`=1: `pc` <= `pc`+`PC_STEP` (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and -> FETCH. Without ready, hold.
- HALT: all handshake outputs 0, `pc` frozen at offending address, IR holds offending word. Exit only by reset.
- `imem_ack` outside FETCH is ignored; IR unchanged.
- Field outputs are pure wiring from IR and change only on an IR load.
- Reset (any time, including mid-handshake): state=IDLE, `pc`=`RESET_PC`, IR=0, `illegal`=0, `imem_req`=0, `dec_valid`=0, `busy`=0; all field outputs 0. An outstanding memory request is abandoned; a late ack after reset is ignored.

## Timing
- All state, PC and IR updates on the rising `clk` edge; reset acts immediately.
- `imem_req`, `dec_valid`, `busy` are Moore outputs decoded from state registers; no combinational path from any input to any output.
- `start` high at edge k -> `imem_req`=1 in cycle k+1.
- Ack in the cycle `imem_req` is first high -> `dec_valid`=1 the next cycle.
- Zero-wait memory plus `dec_ready` tied high: one instruction retired per 2 cycles.
- Non-R-type word acked at edge n -> `illegal`=1 and `busy`=0 from cycle n+1.

## Structure
- Shared package `mips_rtype_pkg`: state enum/localparams, `OPC_RTYPE`=6'h00, IR field bit positions, funct constants (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A, SRL 6'h02) shared with the control unit and its bench.
- One sub-module: `pc_register` (32-bit register, async active-low reset to `RESET_PC`, load-enable, +`PC_STEP` adder). FSM and IR stay in the top.

## Test plan
- Reset then `start`, memory returns 32'h0022_1820 (add $3,$1,$2) with zero wait -> `dec_valid` 2 cycles after start, `rs`=1, `rt`=2, `rd`=3, `function_code`=6'h20, `pc`=0; after `dec_ready`, `imem_addr`=4.
- Ack delayed 3 cycles -> `imem_req` and `imem_addr` held stable for 4 cycles, no `dec_valid` until the cycle after ack.
- `dec_ready` low 5 cycles in ISSUE -> fields and `pc` unchanged throughout; no new `imem_req`.
- Memory returns 32'h8C22_0000 (lw) -> `illegal`=1, state HALT, `pc` frozen, later `start` and `imem_ack` pulses have no effect.
- `RESET_PC`=32'hFFFF_FFFC, one R-type retired -> next `imem_addr`=32'h0000_0000.
- `rst_n` asserted while `imem_req`=1 -> all outputs 0 immediately; ack arriving next cycle leaves IR=0 and state IDLE.
